// File: rtl/button_conditioner.sv
// Front-panel button conditioner: per channel a 2-FF synchronizer, a consecutive-sample
// debounce filter, registered press/release pulses and a hold-to-step auto-repeat pulse.
module button_conditioner #(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_n_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_step
);

   localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_RELOAD = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_RELOAD = RW'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0] s1;
   logic [NUM_BTN-1:0] s2;
   logic [NUM_BTN-1:0] stable_n;
   logic [NUM_BTN-1:0] accept;
   logic [DW-1:0]      dcnt [NUM_BTN];
   logic [RW-1:0]      rcnt [NUM_BTN];

   // A level change is accepted on the sample that completes a full run of differing samples.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         accept[i] = (s2[i] != stable_n[i]) && (dcnt[i] == DB_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '1;
         s2          <= '1;
         stable_n    <= '1;
         btn_press   <= '0;
         btn_release <= '0;
         btn_step    <= '0;
         dcnt        <= '{default: '0};
         rcnt        <= '{default: '0};
      end else begin
         s1          <= btn_n_in;
         s2          <= s1;
         btn_press   <= accept & ~s2;
         btn_release <= accept & s2;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (s2[i] == stable_n[i]) begin
               dcnt[i] <= '0;
            end else if (accept[i]) begin
               stable_n[i] <= s2[i];
               dcnt[i]     <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end

            // Repeat countdown runs only while held; an accepted release kills it at once.
            if (accept[i] && !s2[i]) begin
               rcnt[i]     <= RD_RELOAD;
               btn_step[i] <= 1'b1;
            end else if (!stable_n[i] && !accept[i]) begin
               if (rcnt[i] == '0) begin
                  rcnt[i]     <= RP_RELOAD;
                  btn_step[i] <= 1'b1;
               end else begin
                  rcnt[i]     <= rcnt[i] - 1'b1;
                  btn_step[i] <= 1'b0;
               end
            end else begin
               rcnt[i]     <= '0;
               btn_step[i] <= 1'b0;
            end
         end
      end
   end

   assign btn_level = ~stable_n;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed scenarios then random pin activity,
// expected outputs from a window-based behavioural model, compared every cycle.
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int DB = 16;
   localparam int RD = 64;
   localparam int RP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_n_in = '1;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_step;

   button_conditioner #(
      .NUM_BTN(NB),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n_in(btn_n_in),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_step(btn_step)
   );

   always #5 clk = ~clk;

   logic [4*NB-1:0] exp_q [$];
   int checks = 0;
   int fails  = 0;
   int ncyc   = 0;

   // Behavioural model state
   logic [NB-1:0] m_p1 = '1;
   logic [NB-1:0] m_p2 = '1;
   logic [NB-1:0] m_lv = '0;
   logic [DB-1:0] win  [NB];
   int            wcnt [NB];
   int            ptime[NB];
   int            t = 0;

   // Level flips once the last DB synchronized samples (since reset) all show the opposite level.
   task automatic model_edge(input logic r, input logic [NB-1:0] pins);
      logic [NB-1:0] old_s2, pr, rl, st;
      int d;
      t++;
      pr = '0; rl = '0; st = '0;
      if (r) begin
         m_p1 = '1;
         m_p2 = '1;
         m_lv = '0;
         for (int ch = 0; ch < NB; ch++) begin
            win[ch]  = '0;
            wcnt[ch] = 0;
         end
      end else begin
         old_s2 = m_p2;
         m_p2   = m_p1;
         m_p1   = pins;
         for (int ch = 0; ch < NB; ch++) begin
            win[ch] = {win[ch][DB-2:0], old_s2[ch]};
            if (wcnt[ch] < DB) wcnt[ch]++;
            if (wcnt[ch] >= DB && (m_lv[ch] ? (win[ch] == '1) : (win[ch] == '0))) begin
               m_lv[ch] = ~m_lv[ch];
               pr[ch]   = m_lv[ch];
               rl[ch]   = ~m_lv[ch];
            end
            if (pr[ch]) begin
               st[ch]    = 1'b1;
               ptime[ch] = t;
            end else if (m_lv[ch]) begin
               d      = t - ptime[ch];
               st[ch] = (d >= RD) && ((d - RD) % RP == 0);
            end
         end
      end
      exp_q.push_back({m_lv, pr, rl, st});
   endtask

   task automatic cyc(input logic r, input logic [NB-1:0] pins);
      @(negedge clk);
      rst      = r;
      btn_n_in = pins;
      model_edge(r, pins);
   endtask

   // Monitor: every cycle the DUT presents a full output vector
   initial begin
      logic [4*NB-1:0] e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {btn_level, btn_press, btn_release, btn_step};
            ncyc++;
            checks++;
            if (g !== e) begin
               fails++;
               $display("FAIL outputs cycle %0d got lvl/prs/rel/stp=%b_%b_%b_%b want %b_%b_%b_%b",
                        ncyc, g[4*NB-1:3*NB], g[3*NB-1:2*NB], g[2*NB-1:NB], g[NB-1:0],
                        e[4*NB-1:3*NB], e[3*NB-1:2*NB], e[2*NB-1:NB], e[NB-1:0]);
            end
         end
      end
   end

   int seg[4] = '{5, 3, 7, 2};

   initial begin
      logic [NB-1:0] pins;
      int            dur[NB];
      pins = '1;
      for (int ch = 0; ch < NB; ch++) begin
         win[ch] = '0; wcnt[ch] = 0; ptime[ch] = 0;
      end

      // Reset then idle
      repeat (3) cyc(1'b1, pins);
      repeat (100) cyc(1'b0, pins);

      // Ch0 clean press, held, released
      pins[0] = 1'b0;
      repeat (100) cyc(1'b0, pins);
      pins[0] = 1'b1;
      repeat (40) cyc(1'b0, pins);

      // Ch1 bounce then steady low
      for (int k = 0; k < 4; k++) begin
         pins[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
         repeat (seg[k]) cyc(1'b0, pins);
      end
      pins[1] = 1'b0;
      repeat (60) cyc(1'b0, pins);
      pins[1] = 1'b1;
      repeat (40) cyc(1'b0, pins);

      // Ch2 long hold with auto-repeat
      pins[2] = 1'b0;
      repeat (218) cyc(1'b0, pins);
      pins[2] = 1'b1;
      repeat (40) cyc(1'b0, pins);

      // All pressed together, ch0 released inside its repeat delay
      pins = '0;
      repeat (48) cyc(1'b0, pins);
      pins[0] = 1'b1;
      repeat (100) cyc(1'b0, pins);
      pins = '1;
      repeat (40) cyc(1'b0, pins);

      // Reset pulse while ch0 held and qualified, with junk on the other pins
      pins[0] = 1'b0;
      repeat (40) cyc(1'b0, pins);
      cyc(1'b1, {pins[2:1] ^ 2'b11, pins[0]});
      repeat (60) cyc(1'b0, pins);
      pins = '1;
      repeat (40) cyc(1'b0, pins);

      // Random bouncy activity with occasional resets
      for (int ch = 0; ch < NB; ch++) dur[ch] = $urandom_range(1, 40);
      for (int n = 0; n < 15000; n++) begin
         for (int ch = 0; ch < NB; ch++) begin
            dur[ch]--;
            if (dur[ch] <= 0) begin
               pins[ch] = ~pins[ch];
               dur[ch]  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : $urandom_range(1, 250);
            end
         end
         if ($urandom_range(0, 1999) == 0) cyc(1'b1, NB'($urandom));
         else cyc(1'b0, pins);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
